// File: rtl/servo_bank.sv
`default_nettype none
// ============================================================================
// servo_bank : multi-channel jog/home servo controller, shared-counter PWM
// Rev 1.0
// ============================================================================
module servo_bank #(
    parameter int N_CH       = 3,
    parameter int POS_W      = 8,
    parameter int HOME_POS   = 128,
    parameter int PERIOD_CYC = 1_000_000,
    parameter int MIN_CYC    = 50_000,
    parameter int SCALE      = 196,
    parameter int STEP_DIV   = 500_000
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      btn_up,
    input  logic                                      btn_down,
    input  logic                                      home,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] sel,
    output logic [N_CH*POS_W-1:0]                     pos,
    output logic [N_CH-1:0]                           servo_pulse,
    output logic                                      homing
);

    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W  = $clog2(PERIOD_CYC) + 1;
    localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [POS_W-1:0] POS_MAX  = '1;
    localparam logic [POS_W-1:0] POS_HOME = POS_W'(HOME_POS);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);

    generate
        if (MIN_CYC + ((2 ** POS_W) - 1) * SCALE >= PERIOD_CYC) begin : g_bad_params
            $error("servo_bank: MIN_CYC + (2**POS_W-1)*SCALE must be below PERIOD_CYC");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        HOMING = 1'b1
    } state_t;

    state_t            state;
    logic              up_s1, up_s2, dn_s1, dn_s2;
    logic              home_s1, home_s2, home_d;
    logic              home_rise;
    logic              jog_up, jog_dn;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [POS_W-1:0]  pos_q      [N_CH];
    logic [POS_W-1:0]  home_step  [N_CH];
    logic              all_home_next;
    logic [CNT_W-1:0]  period_cnt;
    logic [CNT_W-1:0]  width_q    [N_CH];
    logic [CNT_W-1:0]  width_new  [N_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            up_s1   <= 1'b0;
            up_s2   <= 1'b0;
            dn_s1   <= 1'b0;
            dn_s2   <= 1'b0;
            home_s1 <= 1'b0;
            home_s2 <= 1'b0;
            home_d  <= 1'b0;
        end else begin
            up_s1   <= btn_up;
            up_s2   <= up_s1;
            dn_s1   <= btn_down;
            dn_s2   <= dn_s1;
            home_s1 <= home;
            home_s2 <= home_s1;
            home_d  <= home_s2;
        end
    end

    assign home_rise = home_s2 & ~home_d;
    // Pressing both buttons together cancels out.
    assign jog_up    = up_s2 & ~dn_s2;
    assign jog_dn    = dn_s2 & ~up_s2;
    assign tick      = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    always_comb begin
        all_home_next = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            home_step[i] = pos_q[i];
            if (pos_q[i] < POS_HOME) begin
                home_step[i] = pos_q[i] + 1'b1;
            end else if (pos_q[i] > POS_HOME) begin
                home_step[i] = pos_q[i] - 1'b1;
            end
            if (home_step[i] != POS_HOME) begin
                all_home_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            homing <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                pos_q[i] <= POS_HOME;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (home_rise) begin
                        state  <= HOMING;
                        homing <= 1'b1;
                    end else if (tick) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (sel == SEL_W'(i)) begin
                                if (jog_up && (pos_q[i] != POS_MAX)) begin
                                    pos_q[i] <= pos_q[i] + 1'b1;
                                end else if (jog_dn && (pos_q[i] != '0)) begin
                                    pos_q[i] <= pos_q[i] - 1'b1;
                                end
                            end
                        end
                    end
                end
                HOMING: begin
                    if (tick) begin
                        for (int i = 0; i < N_CH; i++) begin
                            pos_q[i] <= home_step[i];
                        end
                        if (all_home_next) begin
                            state  <= IDLE;
                            homing <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    homing <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pos = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos[i*POS_W +: POS_W] = pos_q[i];
            width_new[i] = CNT_W'(MIN_CYC) + CNT_W'(pos_q[i]) * CNT_W'(SCALE);
        end
    end

    // Width is captured once per period so a mid-period jog never reshapes a pulse;
    // at count 0 the freshly computed width drives the first high cycle directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt  <= '0;
            servo_pulse <= '0;
            for (int i = 0; i < N_CH; i++) begin
                width_q[i] <= '0;
            end
        end else begin
            period_cnt <= (period_cnt == PER_LAST) ? '0 : period_cnt + CNT_W'(1);
            for (int i = 0; i < N_CH; i++) begin
                if (period_cnt == '0) begin
                    width_q[i]     <= width_new[i];
                    servo_pulse[i] <= (width_new[i] != '0);
                end else begin
                    servo_pulse[i] <= (period_cnt < width_q[i]);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_bank.sv
`default_nettype none
// ============================================================================
// tb_servo_bank : directed table-driven bench for servo_bank (small params)
// Rev 1.0
// ============================================================================
module tb_servo_bank;

    localparam int N_CH       = 3;
    localparam int POS_W      = 4;
    localparam int HOME_POS   = 8;
    localparam int PERIOD_CYC = 100;
    localparam int MIN_CYC    = 10;
    localparam int SCALE      = 4;
    localparam int STEP_DIV   = 4;

    logic                    clk      = 1'b0;
    logic                    rst      = 1'b1;
    logic                    btn_up   = 1'b0;
    logic                    btn_down = 1'b0;
    logic                    home     = 1'b0;
    logic [1:0]              sel      = 2'd0;
    logic [N_CH*POS_W-1:0]   pos;
    logic [N_CH-1:0]         servo_pulse;
    logic                    homing;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    typedef struct {
        logic [1:0] sel;
        logic       up;
        logic       dn;
        int         ticks;
        int         e0;
        int         e1;
        int         e2;
    } vec_t;

    vec_t vecs [14];

    servo_bank #(
        .N_CH      (N_CH),
        .POS_W     (POS_W),
        .HOME_POS  (HOME_POS),
        .PERIOD_CYC(PERIOD_CYC),
        .MIN_CYC   (MIN_CYC),
        .SCALE     (SCALE),
        .STEP_DIV  (STEP_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .home       (home),
        .sel        (sel),
        .pos        (pos),
        .servo_pulse(servo_pulse),
        .homing     (homing)
    );

    always #5 clk = ~clk;

    // Edges since reset release: ticks land on multiples of 4, period starts on k%100==1.
    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pos_of(input int ch);
        return int'(pos[ch*POS_W +: POS_W]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic align();
        while (ecnt % STEP_DIV != 0) step();
    endtask

    task automatic check_pos(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_pos0"}, pos_of(0), e0);
        check({tag, "_pos1"}, pos_of(1), e1);
        check({tag, "_pos2"}, pos_of(2), e2);
    endtask

    task automatic measure(input int ch, output int w);
        int guard;
        guard = 0;
        w = 0;
        while (servo_pulse[ch] == 1'b1 && guard < 400) begin step(); guard++; end
        while (servo_pulse[ch] == 1'b0 && guard < 400) begin step(); guard++; end
        while (servo_pulse[ch] == 1'b1 && guard < 400) begin step(); guard++; w++; end
        if (guard >= 400) w = -1;
    endtask

    initial begin
        int w;
        int cnt1;
        int cnt2;

        //            sel   up    dn  ticks p0 p1 p2
        vecs[0]  = '{2'd1, 1'b1, 1'b0, 1,  8,  9,  8};
        vecs[1]  = '{2'd1, 1'b1, 1'b0, 3,  8, 12,  8};
        vecs[2]  = '{2'd1, 1'b1, 1'b0, 3,  8, 15,  8};
        vecs[3]  = '{2'd1, 1'b1, 1'b0, 3,  8, 15,  8};
        vecs[4]  = '{2'd1, 1'b0, 1'b0, 1,  8, 15,  8};
        vecs[5]  = '{2'd0, 1'b0, 1'b1, 4,  4, 15,  8};
        vecs[6]  = '{2'd0, 1'b0, 1'b1, 6,  0, 15,  8};
        vecs[7]  = '{2'd0, 1'b1, 1'b1, 5,  0, 15,  8};
        vecs[8]  = '{2'd0, 1'b0, 1'b0, 1,  0, 15,  8};
        vecs[9]  = '{2'd3, 1'b1, 1'b0, 3,  0, 15,  8};
        vecs[10] = '{2'd2, 1'b1, 1'b0, 1,  0, 15,  9};
        vecs[11] = '{2'd2, 1'b1, 1'b0, 2,  0, 15, 11};
        vecs[12] = '{2'd1, 1'b0, 1'b1, 7,  0,  8, 11};
        vecs[13] = '{2'd1, 1'b0, 1'b0, 1,  0,  8, 11};

        repeat (3) step();
        check_pos("in_rst", 8, 8, 8);
        check("in_rst_pulse", int'(servo_pulse), 0);
        check("in_rst_homing", int'(homing), 0);

        rst = 1'b0;
        step();
        check_pos("post_rst", 8, 8, 8);
        check("post_rst_homing", int'(homing), 0);
        for (int c = 0; c < N_CH; c++) begin
            measure(c, w);
            check($sformatf("width_home_ch%0d", c), w, 42);
        end

        align();
        for (int i = 0; i < 14; i++) begin
            sel      = vecs[i].sel;
            btn_up   = vecs[i].up;
            btn_down = vecs[i].dn;
            repeat (4 * vecs[i].ticks) step();
            check_pos($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2);
            check($sformatf("vec%0d_homing", i), int'(homing), 0);
            if (i == 4) begin
                measure(1, w);
                check("width_ch1_max", w, 70);
                measure(0, w);
                check("width_ch0_home", w, 42);
                align();
            end
            if (i == 8) begin
                measure(0, w);
                check("width_ch0_min", w, 10);
                align();
            end
        end

        // Jog channel 2 from 11 to 15 during its 54-cycle pulse.
        while (ecnt % PERIOD_CYC != 0) step();
        cnt1 = 0;
        cnt2 = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (servo_pulse[2] == 1'b1) begin
                if (k <= 100) cnt1++;
                else          cnt2++;
            end
            if (k == 28) begin
                sel    = 2'd2;
                btn_up = 1'b1;
            end
            if (k == 44) begin
                btn_up = 1'b0;
                check("midper_pos2", pos_of(2), 15);
                check("midper_pulse2_high", int'(servo_pulse[2]), 1);
            end
        end
        check("midper_width_old", cnt1, 54);
        check("midper_width_new", cnt2, 70);

        // Homing from {0,8,15} with btn_up held on channel 0.
        home   = 1'b1;
        btn_up = 1'b1;
        sel    = 2'd0;
        for (int k = 1; k <= 56; k++) begin
            step();
            case (k)
                2:  check("home_not_yet", int'(homing), 0);
                3: begin
                    check("home_rise", int'(homing), 1);
                    check("home_pos0_wait", pos_of(0), 0);
                end
                4: begin
                    check_pos("home_t1", 1, 8, 14);
                    check("home_t1_homing", int'(homing), 1);
                end
                8:  home = 1'b0;
                12: home = 1'b1;
                31: begin
                    check_pos("home_t7", 7, 8, 8);
                    check("home_t7_homing", int'(homing), 1);
                end
                32: begin
                    check_pos("home_done", 8, 8, 8);
                    check("home_done_homing", int'(homing), 0);
                end
                36: begin
                    check("idle_jog_up", pos_of(0), 9);
                    btn_up   = 1'b0;
                    btn_down = 1'b1;
                    home     = 1'b0;
                end
                40: begin
                    check("idle_jog_down", pos_of(0), 8);
                    btn_down = 1'b0;
                end
                44: home = 1'b1;
                46: check("home_at_home_pre", int'(homing), 0);
                47: check("home_at_home_enter", int'(homing), 1);
                48: begin
                    check("home_at_home_exit", int'(homing), 0);
                    check_pos("home_at_home", 8, 8, 8);
                    sel    = 2'd1;
                    btn_up = 1'b1;
                    home   = 1'b0;
                end
                56: check("pre_rst_pos1", pos_of(1), 10);
                default: ;
            endcase
        end

        // Reset while channel 0 is mid-pulse.
        w = 0;
        while (servo_pulse[0] != 1'b1 && w < 200) begin step(); w++; end
        check("pre_rst_pulse0", int'(servo_pulse[0]), 1);
        rst = 1'b1;
        step();
        check("mid_rst_pulse", int'(servo_pulse), 0);
        check_pos("mid_rst", 8, 8, 8);
        check("mid_rst_homing", int'(homing), 0);
        step();
        rst    = 1'b0;
        btn_up = 1'b0;
        measure(1, w);
        check("after_rst_width_ch1", w, 42);
        check("after_rst_pos1", pos_of(1), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/servo_bank.md
# servo_bank

Parametrised multi-channel successor to the single-servo button controller for the robotic arm (one channel per axis: X, Y, Z by default). Up/down push-buttons jog the currently selected channel's position at a fixed rate with saturation. A home request ramps every channel back to a common home position. Each channel drives its own glitch-free servo PWM output from one shared period counter, all in the `clk` domain with no derived clocks.

## Interface

Parameters:
- `N_CH`, 3: number of servo channels.
- `POS_W`, 8: position width per channel; range is 0..2^POS_W-1.
- `HOME_POS`, 128: reset and home position for all channels.
- `PERIOD_CYC`, 1_000_000: PWM period in `clk` cycles (20 ms at 50 MHz).
- `MIN_CYC`, 50_000: pulse width at position 0 (1 ms).
- `SCALE`, 196: added pulse cycles per position LSB. Elaboration error unless MIN_CYC + (2^POS_W-1)*SCALE < PERIOD_CYC.
- `STEP_DIV`, 500_000: cycles between step ticks (10 ms).

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_up`, in, 1: asynchronous level; increment the selected channel while held.
- `btn_down`, in, 1: asynchronous level; decrement the selected channel while held.
- `home`, in, 1: asynchronous level; a rising edge starts homing.
- `sel`, in, max(1,$clog2(N_CH)): selected channel, synchronous to `clk`.
- `pos`, out, N_CH*POS_W: packed positions, channel i at [i*POS_W +: POS_W].
- `servo_pulse`, out, N_CH: registered PWM outputs.
- `homing`, out, 1: high while the HOMING state is active.

## Operation

- `btn_up`, `btn_down` and `home` each pass through a 2-FF synchronizer. `home` additionally gets an edge-detect register.
- Tick counter runs freely 0..STEP_DIV-1. `tick` is 1 on the cycle the count equals STEP_DIV-1.
- State machine, reset state IDLE:
  - IDLE: on a synchronized `home` rising edge, go to HOMING. Otherwise, on `tick`, apply the jog rule to channel `sel`.
  - HOMING: on `tick`, every channel not equal to HOME_POS moves one LSB toward it. When all channels equal HOME_POS (checked after the update), return to IDLE. Buttons and `sel` are ignored. Further `home` edges are ignored.
- Jog rule on `tick`:
  - up only: pos+1, saturating at 2^POS_W-1.
  - down only: pos-1, saturating at 0.
  - both or neither: no change.
  - `sel` >= N_CH: no channel changes.
- `sel` is sampled on the tick cycle. Changing `sel` while a button is held moves the new channel from the next tick on.
- PWM:
  - Shared period counter runs 0..PERIOD_CYC-1.
  - At count 0, each channel latches width_i = MIN_CYC + pos_i*SCALE. Arithmetic is unsigned, sized to $clog2(PERIOD_CYC)+1 bits with no overflow.
  - servo_pulse[i] is registered: it is high for the count values 0..width_i-1, using the latched width.
  - A `pos` change mid-period never alters the current pulse.

## Timing

- Reset values: every pos = HOME_POS; servo_pulse = 0; homing = 0; tick and period counters = 0; synchronizers = 0; state IDLE.
- Button latency: a button edge reaches the synchronized level 2 cycles later. A step occurs only on a subsequent `tick`. The updated `pos` is visible the cycle after the tick.
- `homing` rises the cycle after the synchronized `home` edge is detected. It falls the cycle after the tick that makes all channels equal HOME_POS.
- A `home` edge while all channels are already at HOME_POS enters HOMING and exits on the next tick.
- servo_pulse[i] lags the period count by one register. Its first high cycle in each period is the cycle after count 0.
- After reset, the first pulse is width_i = MIN_CYC + HOME_POS*SCALE cycles long.
- Reset asserted mid-operation: all state returns to reset values on the next edge. A pulse in progress is cut low immediately on the next edge.

## Test plan

Bench parameters: N_CH=3, POS_W=4, HOME_POS=8, PERIOD_CYC=100, MIN_CYC=10, SCALE=4, STEP_DIV=4.

- Release reset -> all pos=8, homing=0. Each servo_pulse is high for exactly 42 cycles per 100-cycle period.
- sel=1, hold btn_up for 10 ticks -> pos[1] steps 8..15 and holds at 15. Next period width=70. Channels 0 and 2 stay at 8.
- sel=0, hold btn_down for 10 ticks -> pos[0] saturates at 0; width 10. Then both buttons held for 5 ticks -> pos[0] stays 0.
- sel=3 with btn_up held -> no pos changes. Switch sel to 2 mid-hold -> pos[2] starts incrementing on the next tick.
- Change pos[2] at period count 30 -> the current pulse keeps its old width; the new width applies from the next period.
- From pos={0,8,15}, pulse `home` with btn_up held -> homing high for 8 ticks, ending at pos={8,8,8}. Buttons have no effect during homing. homing falls the cycle after the 8th tick.
- Assert rst mid-pulse -> the next cycle gives all pulses 0, pos=8 and state IDLE.
